embertrail_issue_seq: RTL
=========================

Name: embertrail_issue_seq

Overview:
- Parametrised successor to the fixed dual-issue sequencing in the Embertrail control unit.
- Accepts one decoded instruction packet of LANES 16-bit slots and splits it into hazard-free issue passes.
- Times each lane's multicycle execution, handshakes variable-latency data-memory reads, and produces the next PC.
- Sits between the instruction register/decoder and the register file, ALU and data-memory enables.

Parameters:
- LANES, 2, instruction slots per packet (1..4).
- ADDR_W, 16, PC and branch-target width.
- RESET_PC, 0, oNPC value after reset.
- MEM_TIMEOUT, 15, maximum wait cycles on a memory read before a fault.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous active-high reset.
- iPacketValid  in  1  packet fields are valid; held until oPacketAck.
- oPacketAck  out  1  one-cycle pulse; packet fully retired.
- iPC  in  ADDR_W  PC of the current packet.
- iPktWords  in  3  packet length in 16-bit words (1..LANES).
- iLaneValid  in  LANES  slot contains an instruction.
- iLaneOpCode  in  4*LANES  opcode per lane; lane i is at [4i+:4].
- iLaneDst, iLaneSrcA, iLaneSrcB  in  5*LANES  register selects per lane.
- iLaneUsesB  in  LANES  SrcB is a register (not a small immediate).
- iMemReady  in  LANES  read data valid for that lane.
- iBranchTaken  in  1  lane-0 BEQ compare result.
- iBranchTarget  in  ADDR_W  branch destination.
- oLaneActive  out  LANES  lane is executing in the current pass.
- oLaneWb  out  LANES  one-cycle register-write strobe.
- oLaneMemEn, oLaneMemRW  out  LANES  data-memory enable and write flag.
- oNPC  out  ADDR_W  next PC.
- oNPCValid  out  1  pulse when oNPC is updated.
- oMemFault  out  1  pulse on read timeout.
- oBusy  out  1  state is not S_IDLE.

Behaviour:
- Clock and reset: one clock, iClock; synchronous active-high reset iReset.
- Reset values: all outputs 0; oNPC = RESET_PC; state S_IDLE.
- Reset mid-operation: abort the packet at the next edge; no oLaneWb or oPacketAck is issued.

Opcode classes (package tables):
- ALU class: ADDR..XORI, SHIFTL, SHIFTR, MVR, MVI, LDA. Write Dst, 2 cycles.
- LDR, POP: memory read, minimum 3 cycles; write Dst.
- STR: memory write, 2 cycles, no write-back.
- PUSH: memory write, 2 cycles; write Dst.
- BEQ: 2 cycles, no write-back; legal only in lane 0, otherwise the lane is treated as a NOP.
- Opcode 4'b1111 = NOP: completes immediately, never active.
- PUSH and POP implicitly read and write STACK_REG (30).

Hazard split:
- Pending mask at packet start = iLaneValid.
- A pass issues pending lane j unless some lower pending lane k writes a register that lane j reads (SrcA, SrcB when UsesB) or writes.
- Deferred lanes stay pending for the next pass; lane 0 always issues if pending.

FSM:
- S_IDLE: on iPacketValid, latch the pending mask and go to S_EXEC at cycle count c=1.
- S_EXEC:
  - oLaneActive = pass mask; oLaneMemEn/oLaneMemRW are driven for memory lanes.
  - At c=2, ALU, write-class and PUSH lanes complete; oLaneWb pulses for lanes that write back.
  - Read lanes with c>=3 and iMemReady set complete with oLaneWb that cycle.
  - If all pass lanes are complete, go to S_ADVANCE when the pending mask is empty, otherwise start the next pass at c=1.
  - The counter saturates; the wait for a read starts at c=3.
- Read timeout: if a read lane waits more than MEM_TIMEOUT cycles, pulse oMemFault, drop that lane without write-back, and treat it as complete.
- S_ADVANCE:
  - oNPC = iBranchTarget if lane 0 was BEQ and iBranchTaken; otherwise iPC + iPktWords, modulo 2^ADDR_W (wrap-around).
  - Pulse oNPCValid and oPacketAck, then return to S_IDLE.
- Minimum packet latency: 1 + 2*passes + 1 cycles.

Decomposition:
- Package embertrail_pkg: opcode defines, class-lookup functions (writes_dst, is_mem_read, is_mem_write, uses_stack), STACK_REG, state encoding.
- Sub-module embertrail_hazard_mask (combinational): takes the pending mask and register selects, returns the pass mask.

Test Plan:
- Non-dependent lanes: lane0 ADDR r1,r2,r3 and lane1 XORI r4,r5, iPC=0x0010, iPktWords=2. One pass; oLaneWb=2'b11 at c=2; oNPC=0x0012 with oNPCValid one cycle later; total 4 cycles.
- RAW dependency: lane0 ADDR r1 and lane1 ANDI reads r1. Two passes; oLaneWb=01 then 10; oNPC=iPC+2; total 6 cycles.
- Stalled read: lane0 LDR with iMemReady held low for 4 cycles after c=3. oLaneWb[0] asserts in the cycle iMemReady rises; lane1 MVI has already written back at c=2.
- Branch: lane0 BEQ with iBranchTaken=1, iBranchTarget=0x00A0. oNPC=0x00A0. With iBranchTaken=0 at iPC=0xFFFF and iPktWords=2, oNPC=0x0001 (wrap-around).
- Stack ops: PUSH in lane0 and POP in lane1. The pair splits on STACK_REG. A read stall longer than MEM_TIMEOUT=15 pulses oMemFault with no oLaneWb[1], and the packet still acks.
- Reset: assert iReset at c=2 of a 3-cycle LDR pass. Next cycle all outputs are 0 and oNPC=RESET_PC; no oPacketAck.

Source files
------------

// File: rtl/embertrail_pkg.sv
// Embertrail opcode map, execution-class lookups and sequencer state encoding.
package embertrail_pkg;

    localparam logic [4:0] STACK_REG = 5'd30;

    typedef enum logic [3:0] {
        OP_ADDR   = 4'd0,
        OP_SUBR   = 4'd1,
        OP_ANDI   = 4'd2,
        OP_ORI    = 4'd3,
        OP_XORI   = 4'd4,
        OP_SHIFTL = 4'd5,
        OP_SHIFTR = 4'd6,
        OP_MVR    = 4'd7,
        OP_MVI    = 4'd8,
        OP_LDA    = 4'd9,
        OP_LDR    = 4'd10,
        OP_POP    = 4'd11,
        OP_STR    = 4'd12,
        OP_PUSH   = 4'd13,
        OP_BEQ    = 4'd14,
        OP_NOP    = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_ADVANCE = 2'd2
    } state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return op <= OP_LDA;
    endfunction

    function automatic logic is_mem_read(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_POP);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_PUSH);
    endfunction

    function automatic logic uses_stack(input logic [3:0] op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

    function automatic logic writes_dst(input logic [3:0] op);
        return is_alu(op) || is_mem_read(op) || (op == OP_PUSH);
    endfunction

endpackage

// File: rtl/embertrail_issue_seq_if.sv
// Packet, memory-handshake and next-PC bundle between decoder side and issue sequencer.
interface embertrail_issue_seq_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 16
);
    logic                 iPacketValid;
    logic                 oPacketAck;
    logic [ADDR_W-1:0]    iPC;
    logic [2:0]           iPktWords;
    logic [LANES-1:0]     iLaneValid;
    logic [4*LANES-1:0]   iLaneOpCode;
    logic [5*LANES-1:0]   iLaneDst;
    logic [5*LANES-1:0]   iLaneSrcA;
    logic [5*LANES-1:0]   iLaneSrcB;
    logic [LANES-1:0]     iLaneUsesB;
    logic [LANES-1:0]     iMemReady;
    logic                 iBranchTaken;
    logic [ADDR_W-1:0]    iBranchTarget;
    logic [LANES-1:0]     oLaneActive;
    logic [LANES-1:0]     oLaneWb;
    logic [LANES-1:0]     oLaneMemEn;
    logic [LANES-1:0]     oLaneMemRW;
    logic [ADDR_W-1:0]    oNPC;
    logic                 oNPCValid;
    logic                 oMemFault;
    logic                 oBusy;

    modport master (
        output iPacketValid, iPC, iPktWords, iLaneValid, iLaneOpCode, iLaneDst,
               iLaneSrcA, iLaneSrcB, iLaneUsesB, iMemReady, iBranchTaken, iBranchTarget,
        input  oPacketAck, oLaneActive, oLaneWb, oLaneMemEn, oLaneMemRW, oNPC,
               oNPCValid, oMemFault, oBusy
    );

    modport slave (
        input  iPacketValid, iPC, iPktWords, iLaneValid, iLaneOpCode, iLaneDst,
               iLaneSrcA, iLaneSrcB, iLaneUsesB, iMemReady, iBranchTaken, iBranchTarget,
        output oPacketAck, oLaneActive, oLaneWb, oLaneMemEn, oLaneMemRW, oNPC,
               oNPCValid, oMemFault, oBusy
    );

endinterface

// File: rtl/embertrail_hazard_mask.sv
// Picks the lanes of the pending set that can issue together without a register hazard.
module embertrail_hazard_mask
    import embertrail_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]   pendingMask_i,
    input  logic [4*LANES-1:0] laneOpCode_i,
    input  logic [5*LANES-1:0] laneDst_i,
    input  logic [5*LANES-1:0] laneSrcA_i,
    input  logic [5*LANES-1:0] laneSrcB_i,
    input  logic [LANES-1:0]   laneUsesB_i,
    output logic [LANES-1:0]   passMask_o
);

    function automatic logic touches(input logic [4:0] r, input logic [3:0] op,
                                     input logic [4:0] dst, input logic [4:0] srcA,
                                     input logic [4:0] srcB, input logic usesB);
        logic hit;
        hit = 1'b0;
        if (op != OP_NOP) begin
            if (srcA == r) hit = 1'b1;
            if (usesB && (srcB == r)) hit = 1'b1;
            if (writes_dst(op) && (dst == r)) hit = 1'b1;
            if (uses_stack(op) && (r == STACK_REG)) hit = 1'b1;
        end
        return hit;
    endfunction

    // A pending lane is held back when any lower pending lane writes a register it touches
    always_comb begin
        passMask_o = '0;
        for (int j = 0; j < LANES; j++) begin
            passMask_o[j] = pendingMask_i[j];
            for (int k = 0; k < j; k++) begin
                if (pendingMask_i[k]) begin
                    if (writes_dst(laneOpCode_i[4*k +: 4]) &&
                        touches(laneDst_i[5*k +: 5], laneOpCode_i[4*j +: 4], laneDst_i[5*j +: 5],
                                laneSrcA_i[5*j +: 5], laneSrcB_i[5*j +: 5], laneUsesB_i[j]))
                        passMask_o[j] = 1'b0;
                    if (uses_stack(laneOpCode_i[4*k +: 4]) &&
                        touches(STACK_REG, laneOpCode_i[4*j +: 4], laneDst_i[5*j +: 5],
                                laneSrcA_i[5*j +: 5], laneSrcB_i[5*j +: 5], laneUsesB_i[j]))
                        passMask_o[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/embertrail_issue_seq.sv
// Splits a decoded packet into hazard-free passes, times each lane and produces the next PC.
module embertrail_issue_seq
    import embertrail_pkg::*;
#(
    parameter int                LANES       = 2,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic                  iClock,
    input  logic                  iReset,
    embertrail_issue_seq_if.slave bus
);

    localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_READ  = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_FAULT = CNT_W'(MEM_TIMEOUT + 3);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [LANES-1:0]   pending_q, pending_d;
    logic [LANES-1:0]   done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  npc_q, npc_d;

    logic [4*LANES-1:0] effOp;
    logic [LANES-1:0]   isNop, isRead, isWrite, writesDst;
    logic [LANES-1:0]   passMask, activeMask, doneNow;
    logic [ADDR_W-1:0]  nextPc;
    logic               branchTaken;

    // Per-lane decode; a BEQ outside lane 0 is demoted to a NOP
    always_comb begin
        logic [3:0] op;
        op        = OP_NOP;
        effOp     = '0;
        isNop     = '0;
        isRead    = '0;
        isWrite   = '0;
        writesDst = '0;
        for (int i = 0; i < LANES; i++) begin
            op = bus.iLaneOpCode[4*i +: 4];
            if ((i != 0) && (op == OP_BEQ)) op = OP_NOP;
            effOp[4*i +: 4] = op;
            isNop[i]        = (op == OP_NOP);
            isRead[i]       = is_mem_read(op);
            isWrite[i]      = is_mem_write(op);
            writesDst[i]    = writes_dst(op);
        end
    end

    embertrail_hazard_mask #(.LANES(LANES)) uHazard (
        .pendingMask_i (pending_q),
        .laneOpCode_i  (effOp),
        .laneDst_i     (bus.iLaneDst),
        .laneSrcA_i    (bus.iLaneSrcA),
        .laneSrcB_i    (bus.iLaneSrcB),
        .laneUsesB_i   (bus.iLaneUsesB),
        .passMask_o    (passMask)
    );

    assign activeMask  = passMask & ~isNop;
    assign branchTaken = bus.iLaneValid[0] && (bus.iLaneOpCode[3:0] == OP_BEQ) && bus.iBranchTaken;
    assign nextPc      = branchTaken ? bus.iBranchTarget : bus.iPC + ADDR_W'(bus.iPktWords);
    assign bus.oNPC    = (state_q == S_ADVANCE) ? nextPc : npc_q;
    assign bus.oBusy   = (state_q != S_IDLE);

    // Sequencer registers; reset drops any packet in flight
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            npc_q     <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            npc_q     <= npc_d;
        end
    end

    // Next-state, per-lane completion and strobe generation
    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        done_d          = done_q;
        cnt_d           = cnt_q;
        npc_d           = npc_q;
        doneNow         = '0;
        bus.oLaneActive = '0;
        bus.oLaneWb     = '0;
        bus.oLaneMemEn  = '0;
        bus.oLaneMemRW  = '0;
        bus.oNPCValid   = 1'b0;
        bus.oPacketAck  = 1'b0;
        bus.oMemFault   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.iPacketValid) begin
                    pending_d = bus.iLaneValid;
                    done_d    = '0;
                    cnt_d     = CNT_ONE;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.oLaneActive = activeMask;
                bus.oLaneMemEn  = activeMask & (isRead | isWrite);
                bus.oLaneMemRW  = activeMask & isWrite;
                for (int i = 0; i < LANES; i++) begin
                    if (passMask[i] && !done_q[i]) begin
                        if (isNop[i]) begin
                            doneNow[i] = 1'b1;
                        end else if (isRead[i]) begin
                            if ((cnt_q >= CNT_READ) && bus.iMemReady[i]) begin
                                doneNow[i]     = 1'b1;
                                bus.oLaneWb[i] = 1'b1;
                            end else if (cnt_q >= CNT_FAULT) begin
                                doneNow[i]    = 1'b1;
                                bus.oMemFault = 1'b1;
                            end
                        end else if (cnt_q == CNT_TWO) begin
                            doneNow[i]     = 1'b1;
                            bus.oLaneWb[i] = writesDst[i];
                        end
                    end
                end
                if (((done_q | doneNow) & passMask) == passMask) begin
                    pending_d = pending_q & ~passMask;
                    done_d    = '0;
                    cnt_d     = CNT_ONE;
                    state_d   = (pending_d == '0) ? S_ADVANCE : S_EXEC;
                end else begin
                    done_d = done_q | doneNow;
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            S_ADVANCE: begin
                npc_d          = nextPc;
                bus.oNPCValid  = 1'b1;
                bus.oPacketAck = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (iReset) begin
            bus.oLaneWb    = '0;
            bus.oNPCValid  = 1'b0;
            bus.oPacketAck = 1'b0;
            bus.oMemFault  = 1'b0;
        end
    end

endmodule
